// File: rtl/if_stage_sram.sv
// if_stage_sram: instruction-fetch stage of the 5-stage MIPS pipeline.
//
// This block fetches one instruction at a time over a split address/data
// SRAM handshake. It keeps that instruction in a single-entry slot and hands
// it to decode using valid/allowin flow control. The next PC comes from the
// branch bus at handoff time, and there is exactly one delay slot.
//
// Ports
//   clk               rising-edge clock
//   resetn            asynchronous active-low reset
//   ds_allowin        decode accepts an instruction this cycle
//   br_bus            {br_taken, br_target} from decode (combinational)
//   fs_to_ds_valid    slot holds a fetched instruction
//   fs_to_ds_bus      {inst_buf, slot_pc}; the pc field is always live
//   inst_sram_req     fetch request (held until addr_ok)
//   inst_sram_addr    fetch address, always slot_pc
//   inst_sram_addr_ok request accepted this cycle
//   inst_sram_data_ok read data returned this cycle
//   inst_sram_rdata   instruction word, valid with data_ok
module if_stage_sram #(
  parameter logic [31:0] RESET_PC        = 32'hbfc0_0000,
  parameter int          FS_TO_DS_BUS_WD = 64,
  parameter int          BR_BUS_WD       = 33
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_req,
  output logic [31:0]                inst_sram_addr,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FULL = 2'd3
  } fs_state_e;

  fs_state_e   state;
  fs_state_e   state_nx;
  logic [31:0] slot_pc;
  logic [31:0] slot_pc_nx;
  logic [31:0] inst_buf;
  logic [31:0] inst_buf_nx;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] next_pc;

  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // Decode holds the branch while the delay slot sits here. So a taken
  // branch that is still asserted at the delay slot's handoff redirects the
  // fetch that follows the delay slot. The +4 wraps naturally in 32 bits.
  assign next_pc = br_taken ? br_target : slot_pc + 32'd4;

  // Every output decodes straight from registered state.
  assign inst_sram_req  = (state == REQ);
  assign inst_sram_addr = slot_pc;
  assign fs_to_ds_valid = (state == FULL);
  assign fs_to_ds_bus   = {inst_buf, slot_pc};

  // State register: the slot's PC and instruction word live here
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      slot_pc  <= RESET_PC;
      inst_buf <= 32'd0;
    end else begin
      state    <= state_nx;
      slot_pc  <= slot_pc_nx;
      inst_buf <= inst_buf_nx;
    end
  end

  // Next-state logic. data_ok counts only in WAIT, so a stray response
  // outside WAIT cannot corrupt the slot. br_bus is looked at only at handoff.
  always_comb begin
    state_nx    = state;
    slot_pc_nx  = slot_pc;
    inst_buf_nx = inst_buf;
    unique case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        if (inst_sram_addr_ok) state_nx = WAIT;
      end
      WAIT: begin
        if (inst_sram_data_ok) begin
          inst_buf_nx = inst_sram_rdata;
          state_nx    = FULL;
        end
      end
      FULL: begin
        if (ds_allowin) begin
          slot_pc_nx = next_pc;
          state_nx   = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_if_stage_sram.sv
module tb_if_stage_sram;

  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk;
  logic        resetn;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // SRAM responder configuration (written by the main sequence only)
  int addr_lat  = 0;
  int data_lat  = 0;
  bit rand_lat  = 0;
  int stray_req = 0;

  logic [31:0] exp_pc;

  if_stage_sram #(
    .RESET_PC(RESET_PC),
    .FS_TO_DS_BUS_WD(64),
    .BR_BUS_WD(33)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ds_allowin(ds_allowin),
    .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hc001_d00d;
  endfunction

  // SRAM responder. It drives addr_ok/data_ok 2ns after each edge, for the
  // edge that follows. Reset drops the in-flight request.
  int          stray_done = 0;
  bit          in_req     = 0;
  int          waited     = 0;
  int          cur_alat   = 0;
  bit          pending    = 0;
  int          d_wait     = 0;
  logic [31:0] acc_addr   = 32'd0;

  initial begin
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      if (!resetn) begin
        in_req  = 0;
        pending = 0;
      end else if (stray_done < stray_req) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = 32'hdead_beef;
        stray_done++;
      end else if (pending) begin
        if (d_wait == 0) begin
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = imem(acc_addr);
          pending = 0;
        end else begin
          d_wait--;
        end
      end else if (inst_sram_req) begin
        if (!in_req) begin
          in_req   = 1;
          waited   = 0;
          cur_alat = rand_lat ? int'($urandom_range(0, 3)) : addr_lat;
        end
        if (waited >= cur_alat) begin
          inst_sram_addr_ok = 1'b1;
          acc_addr = inst_sram_addr;
          pending  = 1;
          d_wait   = rand_lat ? int'($urandom_range(0, 3)) : data_lat;
          in_req   = 0;
        end else begin
          waited++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (act=timeout req=finish)");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    ds_allowin = 1'b0;
    br_bus     = 33'd0;
    cyc();
    cyc();
    resetn = 1'b1;
    exp_pc = RESET_PC;
  endtask

  task automatic test_reset();
    ds_allowin = 1'b0;
    br_bus     = 33'd0;
    cyc();
    cyc();
    cyc();
    n_cmp++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid act=%b req=0", fs_to_ds_valid); end
    n_cmp++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL reset_req act=%b req=0", inst_sram_req); end
    n_cmp++; if (inst_sram_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr act=%h req=%h", inst_sram_addr, RESET_PC); end
    n_cmp++; if (fs_to_ds_bus !== {32'd0, RESET_PC}) begin n_fail++; $display("FAIL reset_bus act=%h req=%h", fs_to_ds_bus, {32'd0, RESET_PC}); end
  endtask

  task automatic test_boot();
    logic [31:0] pc_k;
    logic        e_req;
    logic        e_vld;
    addr_lat   = 0;
    data_lat   = 0;
    ds_allowin = 1'b1;
    resetn     = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      e_req = (k % 3 == 1);
      e_vld = (k % 3 == 0);
      pc_k  = RESET_PC + 32'(4 * ((k - 1) / 3));
      n_cmp++; if (inst_sram_req !== e_req) begin n_fail++; $display("FAIL boot_req k=%0d act=%b req=%b", k, inst_sram_req, e_req); end
      n_cmp++; if (fs_to_ds_valid !== e_vld) begin n_fail++; $display("FAIL boot_valid k=%0d act=%b req=%b", k, fs_to_ds_valid, e_vld); end
      n_cmp++; if (inst_sram_addr !== pc_k) begin n_fail++; $display("FAIL boot_addr k=%0d act=%h req=%h", k, inst_sram_addr, pc_k); end
      if (e_vld) begin
        n_cmp++; if (fs_to_ds_bus !== {imem(pc_k), pc_k}) begin n_fail++; $display("FAIL boot_bus k=%0d act=%h req=%h", k, fs_to_ds_bus, {imem(pc_k), pc_k}); end
      end
    end
  endtask

  task automatic test_wait_states();
    int   pulses = 0;
    int   reqlen = 0;
    logic prev_req = 1'b0;
    addr_lat = 3;
    data_lat = 2;
    do_reset();
    ds_allowin = 1'b1;
    for (int c = 0; c < 60 && pulses < 3; c++) begin
      cyc();
      if (inst_sram_req) begin
        n_cmp++; if (inst_sram_addr !== exp_pc) begin n_fail++; $display("FAIL wait_addr act=%h req=%h", inst_sram_addr, exp_pc); end
        reqlen++;
      end else if (prev_req) begin
        n_cmp++; if (reqlen != 4) begin n_fail++; $display("FAIL wait_reqlen act=%0d req=4", reqlen); end
        reqlen = 0;
      end
      if (fs_to_ds_valid) begin
        n_cmp++; if (fs_to_ds_bus !== {imem(exp_pc), exp_pc}) begin n_fail++; $display("FAIL wait_bus act=%h req=%h", fs_to_ds_bus, {imem(exp_pc), exp_pc}); end
        pulses++;
        exp_pc = exp_pc + 32'd4;
      end
      prev_req = inst_sram_req;
    end
    n_cmp++; if (pulses != 3) begin n_fail++; $display("FAIL wait_pulses act=%0d req=3", pulses); end
    addr_lat = 0;
    data_lat = 0;
  endtask

  task automatic test_backpressure();
    bit found = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (fs_to_ds_valid) begin
        found = 1;
        break;
      end
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL bp_first_valid act=0 req=1"); end
    for (int i = 0; i <= 5; i++) begin
      n_cmp++; if (fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid i=%0d act=%b req=1", i, fs_to_ds_valid); end
      n_cmp++; if (inst_sram_req !== 1'b0) begin n_fail++; $display("FAIL bp_req i=%0d act=%b req=0", i, inst_sram_req); end
      n_cmp++; if (fs_to_ds_bus !== {imem(RESET_PC), RESET_PC}) begin n_fail++; $display("FAIL bp_bus i=%0d act=%h req=%h", i, fs_to_ds_bus, {imem(RESET_PC), RESET_PC}); end
      if (i < 5) cyc();
    end
    ds_allowin = 1'b1;
    cyc();
    ds_allowin = 1'b0;
    n_cmp++; if (inst_sram_req !== 1'b1) begin n_fail++; $display("FAIL bp_next_req act=%b req=1", inst_sram_req); end
    n_cmp++; if (inst_sram_addr !== RESET_PC + 32'd4) begin n_fail++; $display("FAIL bp_next_addr act=%h req=%h", inst_sram_addr, RESET_PC + 32'd4); end
    n_cmp++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL bp_next_valid act=%b req=0", fs_to_ds_valid); end
  endtask

  task automatic test_branch();
    bit seen_tgt = 0;
    do_reset();
    ds_allowin = 1'b1;
    for (int c = 0; c < 60; c++) begin
      cyc();
      if (inst_sram_req) begin
        n_cmp++; if (inst_sram_addr !== exp_pc) begin n_fail++; $display("FAIL br_addr act=%h req=%h", inst_sram_addr, exp_pc); end
      end
      if (fs_to_ds_valid) begin
        n_cmp++; if (fs_to_ds_bus !== {imem(exp_pc), exp_pc}) begin n_fail++; $display("FAIL br_bus act=%h req=%h", fs_to_ds_bus, {imem(exp_pc), exp_pc}); end
        if (exp_pc == 32'hbfc0_0100) begin
          seen_tgt = 1;
          break;
        end
        if (exp_pc == 32'hbfc0_0014) begin
          br_bus = {1'b1, 32'hbfc0_0100};
          exp_pc = 32'hbfc0_0100;
        end else begin
          br_bus = {1'b0, 32'($urandom)};
          exp_pc = exp_pc + 32'd4;
        end
      end else begin
        // A taken branch seen outside a handoff cycle must have no effect.
        br_bus = {1'b1, 32'($urandom) & ~32'd3};
      end
    end
    br_bus     = 33'd0;
    ds_allowin = 1'b0;
    n_cmp++; if (!seen_tgt) begin n_fail++; $display("FAIL br_target_reached act=0 req=1"); end
  endtask

  task automatic test_reset_wrap();
    int cnt       = 0;
    int first_vld = -1;
    bit wrapped   = 0;
    addr_lat = 0;
    data_lat = 2;
    do_reset();
    ds_allowin = 1'b1;
    for (int c = 0; c < 40 && cnt < 2; c++) begin
      cyc();
      if (fs_to_ds_valid) begin
        exp_pc = exp_pc + 32'd4;
        cnt++;
      end
    end
    cyc();
    cyc();
    n_cmp++; if ({inst_sram_req, fs_to_ds_valid} !== 2'b00) begin n_fail++; $display("FAIL rw_in_wait act=%b req=00", {inst_sram_req, fs_to_ds_valid}); end
    resetn = 1'b0;
    #1;
    n_cmp++; if (fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL rw_reset_valid act=%b req=0", fs_to_ds_valid); end
    n_cmp++; if (inst_sram_addr !== RESET_PC) begin n_fail++; $display("FAIL rw_reset_addr act=%h req=%h", inst_sram_addr, RESET_PC); end
    n_cmp++; if (fs_to_ds_bus !== {32'd0, RESET_PC}) begin n_fail++; $display("FAIL rw_reset_bus act=%h req=%h", fs_to_ds_bus, {32'd0, RESET_PC}); end
    cyc();
    cyc();
    ds_allowin = 1'b0;
    addr_lat   = 2;
    exp_pc     = RESET_PC;
    resetn     = 1'b1;
    stray_req  = stray_req + 2;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (inst_sram_req) begin
        n_cmp++; if (inst_sram_addr !== exp_pc) begin n_fail++; $display("FAIL rw_addr k=%0d act=%h req=%h", k, inst_sram_addr, exp_pc); end
      end
      if (fs_to_ds_valid) begin
        n_cmp++; if (fs_to_ds_bus !== {imem(exp_pc), exp_pc}) begin n_fail++; $display("FAIL rw_bus k=%0d act=%h req=%h", k, fs_to_ds_bus, {imem(exp_pc), exp_pc}); end
        if (first_vld < 0) first_vld = k;
      end
    end
    n_cmp++; if (first_vld != 8) begin n_fail++; $display("FAIL rw_first_valid act=%0d req=8", first_vld); end
    addr_lat   = 0;
    data_lat   = 0;
    br_bus     = {1'b1, 32'hffff_fffc};
    ds_allowin = 1'b1;
    exp_pc     = 32'hffff_fffc;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (inst_sram_req) begin
        n_cmp++; if (inst_sram_addr !== exp_pc) begin n_fail++; $display("FAIL wrap_addr act=%h req=%h", inst_sram_addr, exp_pc); end
        if (exp_pc == 32'd0) begin
          wrapped = 1;
          break;
        end
      end
      if (fs_to_ds_valid) begin
        n_cmp++; if (fs_to_ds_bus !== {imem(exp_pc), exp_pc}) begin n_fail++; $display("FAIL wrap_bus act=%h req=%h", fs_to_ds_bus, {imem(exp_pc), exp_pc}); end
        br_bus = {1'b0, 32'($urandom)};
        exp_pc = exp_pc + 32'd4;
      end else begin
        br_bus = {1'b1, 32'($urandom) & ~32'd3};
      end
    end
    br_bus = 33'd0;
    n_cmp++; if (!wrapped) begin n_fail++; $display("FAIL wrap_reached act=0 req=1"); end
  endtask

  task automatic test_random();
    int          handoffs = 0;
    logic        p_valid  = 1'b0;
    logic        p_allow  = 1'b0;
    logic        p_req    = 1'b0;
    logic [63:0] p_bus    = 64'd0;
    rand_lat = 1;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      cyc();
      n_cmp++; if (inst_sram_req && fs_to_ds_valid) begin n_fail++; $display("FAIL rnd_req_and_valid c=%0d act=11 req=not11", c); end
      n_cmp++; if (fs_to_ds_bus[31:0] !== exp_pc) begin n_fail++; $display("FAIL rnd_bus_pc c=%0d act=%h req=%h", c, fs_to_ds_bus[31:0], exp_pc); end
      if (inst_sram_req) begin
        n_cmp++; if (inst_sram_addr !== exp_pc) begin n_fail++; $display("FAIL rnd_addr c=%0d act=%h req=%h", c, inst_sram_addr, exp_pc); end
      end
      if (fs_to_ds_valid) begin
        n_cmp++; if (fs_to_ds_bus[63:32] !== imem(exp_pc)) begin n_fail++; $display("FAIL rnd_inst c=%0d act=%h req=%h", c, fs_to_ds_bus[63:32], imem(exp_pc)); end
      end
      if (p_valid && !p_allow) begin
        n_cmp++; if ({fs_to_ds_valid, inst_sram_req} !== 2'b10 || fs_to_ds_bus !== p_bus) begin n_fail++; $display("FAIL rnd_hold c=%0d act=%b/%h req=10/%h", c, {fs_to_ds_valid, inst_sram_req}, fs_to_ds_bus, p_bus); end
      end
      if (p_req && !inst_sram_addr_ok) begin
        n_cmp++; if (inst_sram_req !== 1'b1) begin n_fail++; $display("FAIL rnd_req_drop c=%0d act=%b req=1", c, inst_sram_req); end
      end
      p_valid = fs_to_ds_valid;
      p_req   = inst_sram_req;
      p_bus   = fs_to_ds_bus;
      ds_allowin = ($urandom_range(0, 9) < 7);
      br_bus     = {($urandom_range(0, 3) == 0), 32'($urandom) & ~32'd3};
      if (fs_to_ds_valid && ds_allowin) begin
        exp_pc = br_bus[32] ? br_bus[31:0] : exp_pc + 32'd4;
        handoffs++;
      end
      p_allow = ds_allowin;
    end
    n_cmp++; if (handoffs < 30) begin n_fail++; $display("FAIL rnd_handoffs act=%0d req>=30", handoffs); end
    rand_lat   = 0;
    ds_allowin = 1'b0;
    br_bus     = 33'd0;
  endtask

  initial begin
    resetn     = 1'b0;
    ds_allowin = 1'b0;
    br_bus     = 33'd0;
    exp_pc     = RESET_PC;
    test_reset();
    test_boot();
    test_wait_states();
    test_backpressure();
    test_branch();
    test_reset_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
